fifo_sync_prog: RTL and testbench
=================================

FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

Interface
REQ-001 Parameter DATA_W, default 32: payload width in bits.
REQ-002 Parameter DEPTH, default 16: entry count, any integer >= 2, not restricted to powers of two.
REQ-003 Parameter FWFT, default 0: 0 = registered read data, 1 = first-word-fall-through.
REQ-004 Parameter AF_LEVEL, default DEPTH-2: almost_full threshold; legal range 1..DEPTH.
REQ-005 Parameter AE_LEVEL, default 2: almost_empty threshold; legal range 0..DEPTH-1.
REQ-006 Out-of-range parameters SHALL cause an elaboration error.
REQ-007 Localparam LVL_W = $clog2(DEPTH+1).
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rst_n  in  1  synchronous active-low reset.
REQ-010 flush  in  1  synchronous empty request.
REQ-011 wr_en  in  1  write request.
REQ-012 wr_data  in  DATA_W  write payload.
REQ-013 full  out  1  level == DEPTH.
REQ-014 almost_full  out  1  level >= AF_LEVEL.
REQ-015 rd_en  in  1  read request / pop.
REQ-016 rd_data  out  DATA_W  read payload.
REQ-017 empty  out  1  level == 0.
REQ-018 almost_empty  out  1  level <= AE_LEVEL.
REQ-019 level  out  LVL_W  current occupancy, 0..DEPTH.
REQ-020 overflow  out  1  sticky: write rejected.
REQ-021 underflow  out  1  sticky: read rejected.

Function
REQ-022 All status outputs SHALL derive only from registered state; no combinational path from wr_en/rd_en to any status output.
REQ-023 rd_acc = rd_en & ~empty; wr_acc = wr_en & (~full | rd_acc).
- A write while full SHALL be accepted when a read is accepted in the same cycle.
REQ-024 Level update: wr_acc only -> +1; rd_acc only -> -1; both or neither -> unchanged.
REQ-025 Write pointer SHALL advance on wr_acc; read pointer on rd_acc; each wraps from DEPTH-1 to 0.
REQ-026 Write while empty with rd_en=1: write accepted, read rejected; no same-cycle bypass.
REQ-027 FWFT=0:
- rd_data SHALL update to the head entry on the clock edge of rd_acc, visible the next cycle.
- rd_data SHALL hold its value otherwise.
REQ-028 FWFT=1:
- rd_data SHALL present the head entry combinationally from registered state whenever empty=0, and 0 when empty=1.
- rd_acc pops the head entry.
- A word written into an empty FIFO SHALL appear on rd_data one cycle after its write.
REQ-029 overflow SHALL set on wr_en & ~wr_acc; underflow SHALL set on rd_en & empty.
- Both hold until flush or reset.
REQ-030 flush=1 SHALL have priority over wr_en/rd_en:
- pointers and level go to 0; overflow and underflow clear.
- rd_data goes to 0 (FWFT=0).
- Requests in the flush cycle are ignored and SHALL NOT set error flags.
REQ-031 Memory contents SHALL NOT be cleared by flush or reset.
REQ-032 Single clock domain; no multicycle paths.

Reset
REQ-033 rst_n=0 at a rising edge SHALL take priority over flush and all requests.
REQ-034 State after reset:
- level=0, empty=1, full=0, almost_empty=1, almost_full=0.
- overflow=0, underflow=0, rd_data=0.
- pointers at 0.
REQ-035 A reset asserted mid-stream SHALL discard all stored entries; the first read after reset SHALL return the first word written after reset.

Verification
REQ-036 DEPTH=5, FWFT=0: write 0x1..0x5 -> full=1, level=5; write 0x6 -> rejected, overflow=1; 5 reads -> rd_data 0x1..0x5, one cycle after each rd_en.
REQ-037 DEPTH=5: 12 interleaved write/read pairs -> both pointers wrap; read order equals write order; level never exceeds 1.
REQ-038 Full with simultaneous wr_en=1, rd_en=1 -> both accepted; level stays 5; full stays 1; overflow stays 0.
REQ-039 FWFT=1, empty: write 0xA5 -> next cycle empty=0, rd_data=0xA5 with no rd_en; rd_en=1 -> empty=1, rd_data=0.
REQ-040 AF_LEVEL=4, AE_LEVEL=1: step level 0..5 -> almost_empty=1 for levels 0-1; almost_full=1 for levels 4-5.
REQ-041 Level 3 with overflow=1: assert flush with wr_en=1 -> next cycle level=0, empty=1, overflow=0, write dropped; same test with rst_n=0 instead gives identical status.

Source files
------------

// File: rtl/fifo_sync_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a choice of registered or
// first-word-fall-through read data. Any DEPTH >= 2 is supported; the
// pointers wrap explicitly, so DEPTH need not be a power of two.
module fifo_sync_prog #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              almost_empty,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Reject illegal parameterisations at elaboration time.
    if (DATA_W < 1) begin : g_bad_data_w
        $error("fifo_sync_prog: DATA_W must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_prog: DEPTH must be >= 2");
    end
    if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
        $error("fifo_sync_prog: FWFT must be 0 or 1");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("fifo_sync_prog: AF_LEVEL must be in 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
        $error("fifo_sync_prog: AE_LEVEL must be in 0..DEPTH-1");
    end

    // Pointer increment with wrap at DEPTH-1 (DEPTH may be non-power-of-two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic empty_s, full_s, rd_acc_s, wr_acc_s, mem_we_s;

    // Status is decoded purely from the registered level.
    assign empty_s  = (level_q == LVL_W'(0));
    assign full_s   = (level_q == LVL_W'(DEPTH));
    // A write into a full FIFO is allowed when a pop frees a slot this cycle.
    assign rd_acc_s = rd_en & ~empty_s;
    assign wr_acc_s = wr_en & (~full_s | rd_acc_s);
    assign mem_we_s = wr_acc_s & ~flush & rst_n;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            level_d  = {LVL_W{1'b0}};
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
            ovf_d = ovf_q | (wr_en & ~wr_acc_s);
            udf_d = udf_q | (rd_en & empty_s);
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; deliberately not cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    if (FWFT == 0) begin : g_reg_rd
        logic [DATA_W-1:0] rd_data_q, rd_data_d;

        // Registered read data: load the head on a pop, clear on flush, else hold.
        always_comb begin
            rd_data_d = rd_data_q;
            if (flush) begin
                rd_data_d = {DATA_W{1'b0}};
            end else if (rd_acc_s) begin
                rd_data_d = mem_q[rd_ptr_q];
            end else begin
                rd_data_d = rd_data_q;
            end
        end

        // Read data register with synchronous active-low reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_data_q <= {DATA_W{1'b0}};
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign rd_data = rd_data_q;
    end else begin : g_fwft_rd
        // Head entry shown directly from registered state; zero when empty.
        assign rd_data = empty_s ? {DATA_W{1'b0}} : mem_q[rd_ptr_q];
    end

    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (level_q >= LVL_W'(AF_LEVEL));
    assign almost_empty = (level_q <= LVL_W'(AE_LEVEL));
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: two DEPTH=5 instances (registered and FWFT read
// data) share one stimulus stream and are compared every cycle against a
// queue-based reference model, plus literal expectations for key scenarios.
module tb_fifo_sync_prog;

    localparam int DW  = 16;
    localparam int DEP = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = 16'h0000;
    logic          rd_en = 1'b0;

    logic          full_r, afull_r, empty_r, aempty_r, ovf_r, udf_r;
    logic [DW-1:0] rd_data_r;
    logic [2:0]    level_r;
    logic          full_f, afull_f, empty_f, aempty_f, ovf_f, udf_f;
    logic [DW-1:0] rd_data_f;
    logic [2:0]    level_f;

    fifo_sync_prog #(.DATA_W(DW), .DEPTH(DEP), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_r), .almost_full(afull_r), .rd_en(rd_en), .rd_data(rd_data_r),
        .empty(empty_r), .almost_empty(aempty_r), .level(level_r),
        .overflow(ovf_r), .underflow(udf_r)
    );

    fifo_sync_prog #(.DATA_W(DW), .DEPTH(DEP), .FWFT(1), .AF_LEVEL(4), .AE_LEVEL(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full_f), .almost_full(afull_f), .rd_en(rd_en), .rd_data(rd_data_f),
        .empty(empty_f), .almost_empty(aempty_f), .level(level_f),
        .overflow(ovf_f), .underflow(udf_f)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit check_en = 1'b0;

    // Reference model state.
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    logic [DW-1:0] m_rd0 = 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model step for one rising edge, applied with the inputs of that edge.
    task automatic model_step(input bit w, input logic [DW-1:0] d, input bit r,
                              input bit f, input bit rn);
        bit emp, ful, racc, wacc;
        if (!rn || f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_rd0 = 16'h0000;
        end else begin
            emp  = (mq.size() == 0);
            ful  = (mq.size() == DEP);
            racc = r && !emp;
            wacc = w && (!ful || racc);
            if (w && !wacc) m_ovf = 1'b1;
            if (r && emp)   m_udf = 1'b1;
            if (racc) m_rd0 = mq.pop_front();
            if (wacc) mq.push_back(d);
        end
    endtask

    // One clock cycle of stimulus; inputs return to idle shortly after the edge.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit f, input bit rn);
        wr_en = w; wr_data = d; rd_en = r; flush = f; rst_n = rn;
        @(posedge clk);
        model_step(w, d, r, f, rn);
        #2;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst_n = 1'b1;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("level_r",  {29'd0, level_r}, mq.size());
            chk("level_f",  {29'd0, level_f}, mq.size());
            chk("empty_r",  {31'd0, empty_r}, {31'd0, mq.size() == 0});
            chk("empty_f",  {31'd0, empty_f}, {31'd0, mq.size() == 0});
            chk("full_r",   {31'd0, full_r},  {31'd0, mq.size() == DEP});
            chk("full_f",   {31'd0, full_f},  {31'd0, mq.size() == DEP});
            chk("aempty_r", {31'd0, aempty_r}, {31'd0, mq.size() <= 1});
            chk("aempty_f", {31'd0, aempty_f}, {31'd0, mq.size() <= 1});
            chk("afull_r",  {31'd0, afull_r}, {31'd0, mq.size() >= 4});
            chk("afull_f",  {31'd0, afull_f}, {31'd0, mq.size() >= 4});
            chk("ovf_r",    {31'd0, ovf_r}, {31'd0, m_ovf});
            chk("ovf_f",    {31'd0, ovf_f}, {31'd0, m_ovf});
            chk("udf_r",    {31'd0, udf_r}, {31'd0, m_udf});
            chk("udf_f",    {31'd0, udf_f}, {31'd0, m_udf});
            chk("rd_data_r", {16'd0, rd_data_r}, {16'd0, m_rd0});
            chk("rd_data_f", {16'd0, rd_data_f},
                (mq.size() != 0) ? {16'd0, mq[0]} : 32'd0);
        end
    end

    initial begin
        logic [5:0] ae_tab;
        logic [5:0] af_tab;
        ae_tab = 6'b000011;
        af_tab = 6'b110000;

        // Reset and reset-state literals.
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0BAD, 1'b1, 1'b1, 1'b0);
        check_en = 1'b1;
        chk("rst_level", {29'd0, level_r}, 32'd0);
        chk("rst_empty", {31'd0, empty_r}, 32'd1);
        chk("rst_aempty", {31'd0, aempty_r}, 32'd1);
        chk("rst_afull", {31'd0, afull_r}, 32'd0);
        chk("rst_rd_data", {16'd0, rd_data_r}, 32'd0);

        // Fill, overflow, drain with registered read data.
        for (int i = 1; i <= 5; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b1);
        chk("fill_full", {31'd0, full_r}, 32'd1);
        chk("fill_level", {29'd0, level_r}, 32'd5);
        cyc(1'b1, 16'h0006, 1'b0, 1'b0, 1'b1);
        chk("ovf_set", {31'd0, ovf_r}, 32'd1);
        chk("ovf_level", {29'd0, level_r}, 32'd5);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
            chk("drain_data", {16'd0, rd_data_r}, i);
        end
        chk("drain_empty", {31'd0, empty_r}, 32'd1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        chk("udf_set", {31'd0, udf_r}, 32'd1);
        chk("udf_hold_data", {16'd0, rd_data_r}, 32'd5);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        chk("flush_ovf", {31'd0, ovf_r}, 32'd0);
        chk("flush_udf", {31'd0, udf_r}, 32'd0);
        chk("flush_rd_data", {16'd0, rd_data_r}, 32'd0);

        // Interleaved write/read pairs wrap both pointers.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0, 1'b1);
            chk("wrap_level", {29'd0, level_r}, 32'd1);
            cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
            chk("wrap_data", {16'd0, rd_data_r}, 32'h0100 + i);
        end

        // Simultaneous write and read while full.
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(16'h0020 + i), 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'h0030, 1'b1, 1'b0, 1'b1);
        chk("fullrw_level", {29'd0, level_r}, 32'd5);
        chk("fullrw_full", {31'd0, full_r}, 32'd1);
        chk("fullrw_ovf", {31'd0, ovf_r}, 32'd0);
        chk("fullrw_data", {16'd0, rd_data_r}, 32'h0020);

        // First-word-fall-through visibility.
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 16'h00A5, 1'b0, 1'b0, 1'b1);
        chk("fwft_empty", {31'd0, empty_f}, 32'd0);
        chk("fwft_data", {16'd0, rd_data_f}, 32'h00A5);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        chk("fwft_pop_empty", {31'd0, empty_f}, 32'd1);
        chk("fwft_pop_data", {16'd0, rd_data_f}, 32'd0);

        // Threshold sweep across levels 0..5.
        for (int lv = 0; lv <= 5; lv++) begin
            chk("thr_level", {29'd0, level_r}, lv);
            chk("thr_aempty", {31'd0, aempty_r}, {31'd0, ae_tab[lv]});
            chk("thr_afull", {31'd0, afull_r}, {31'd0, af_tab[lv]});
            if (lv < 5) cyc(1'b1, DW'(16'h0040 + lv), 1'b0, 1'b0, 1'b1);
        end

        // Flush with a pending write at level 3 and overflow set.
        cyc(1'b1, 16'h0066, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        chk("l3_level", {29'd0, level_r}, 32'd3);
        chk("l3_ovf", {31'd0, ovf_r}, 32'd1);
        cyc(1'b1, 16'h0077, 1'b0, 1'b1, 1'b1);
        chk("fl_level", {29'd0, level_r}, 32'd0);
        chk("fl_empty", {31'd0, empty_r}, 32'd1);
        chk("fl_ovf", {31'd0, ovf_r}, 32'd0);

        // Same scenario with reset instead of flush.
        for (int i = 0; i < 6; i++) cyc(1'b1, DW'(16'h0050 + i), 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        chk("l3b_ovf", {31'd0, ovf_r}, 32'd1);
        cyc(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
        chk("rs_level", {29'd0, level_r}, 32'd0);
        chk("rs_empty", {31'd0, empty_r}, 32'd1);
        chk("rs_ovf", {31'd0, ovf_r}, 32'd0);

        // Mid-stream reset discards stored entries.
        cyc(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'h0012, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0055, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        chk("postrst_data", {16'd0, rd_data_r}, 32'h0055);

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50,
                $urandom_range(0, 99) < 3, $urandom_range(0, 199) != 0);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
